// File: rtl/fetch_buffer.sv
// Instruction fetch queue between the icache and the 4-wide decode stage.
// Holds up to DEPTH {pc, instr} entries and presents the oldest four as a lane bundle.
module fetch_buffer #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 16,
  parameter int DEPTH_LOG = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic [WIDTH-1:0]       i_pc,
  input  logic [31:0]            i_instr,
  output logic                   o_ready,
  input  logic                   i_dec_ready,
  output logic [3:0]             o_valid,
  output logic [127:0]           o_instr,
  output logic [4*WIDTH-1:0]     o_pc,
  output logic [DEPTH_LOG:0]     o_count
);

  localparam int LANES = 4;
  localparam logic [DEPTH_LOG:0] DEPTH_C = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] LANES_C = (DEPTH_LOG+1)'(LANES);
  localparam logic [31:0]        NOP     = 32'h00000013;

  logic [WIDTH-1:0]     pc_mem_r    [DEPTH];
  logic [31:0]          instr_mem_r [DEPTH];
  logic [DEPTH_LOG-1:0] head_r;
  logic [DEPTH_LOG-1:0] tail_r;
  logic [DEPTH_LOG:0]   count_r;

  logic                 push_s;
  logic                 pop_s;
  logic [DEPTH_LOG:0]   pop_n_s;
  logic [DEPTH_LOG:0]   count_next_s;

  assign o_ready      = (count_r < DEPTH_C);
  assign o_count      = count_r;
  assign push_s       = i_valid && o_ready && !i_flush;
  assign pop_s        = i_dec_ready && !i_flush;
  assign count_next_s = count_r + (DEPTH_LOG+1)'(push_s) - pop_n_s;

  // Number of entries a pop removes: every valid lane, i.e. min(count, LANES).
  always_comb begin
    pop_n_s = {(DEPTH_LOG+1){1'b0}};
    if (!pop_s) begin
      pop_n_s = {(DEPTH_LOG+1){1'b0}};
    end else if (count_r > LANES_C) begin
      pop_n_s = LANES_C;
    end else begin
      pop_n_s = count_r;
    end
  end

  // Lane k shows entry (head+k) mod DEPTH; lanes beyond the occupancy show a NOP at pc 0.
  always_comb begin
    logic [DEPTH_LOG-1:0] idx;
    idx     = {DEPTH_LOG{1'b0}};
    o_valid = 4'b0000;
    o_instr = {LANES{NOP}};
    o_pc    = {(LANES*WIDTH){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      idx = head_r + DEPTH_LOG'(k);
      if (count_r > (DEPTH_LOG+1)'(k)) begin
        o_valid[k]              = 1'b1;
        o_instr[32*k +: 32]     = instr_mem_r[idx];
        o_pc[WIDTH*k +: WIDTH]  = pc_mem_r[idx];
      end else begin
        o_valid[k]              = 1'b0;
        o_instr[32*k +: 32]     = NOP;
        o_pc[WIDTH*k +: WIDTH]  = {WIDTH{1'b0}};
      end
    end
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      pc_mem_r[tail_r]    <= i_pc;
      instr_mem_r[tail_r] <= i_instr;
    end
  end

  // Pointer and occupancy state; flush outranks any concurrent push or pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_r  <= {DEPTH_LOG{1'b0}};
      tail_r  <= {DEPTH_LOG{1'b0}};
      count_r <= {(DEPTH_LOG+1){1'b0}};
    end else if (i_flush) begin
      head_r  <= {DEPTH_LOG{1'b0}};
      tail_r  <= {DEPTH_LOG{1'b0}};
      count_r <= {(DEPTH_LOG+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + {{(DEPTH_LOG-1){1'b0}}, 1'b1};
      end
      head_r  <= DEPTH_LOG'(head_r + pop_n_s);
      count_r <= count_next_s;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer with hand-computed expectations.
module tb_fetch_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_flush;
  logic         i_valid;
  logic [11:0]  i_pc;
  logic [31:0]  i_instr;
  logic         o_ready;
  logic         i_dec_ready;
  logic [3:0]   o_valid;
  logic [127:0] o_instr;
  logic [47:0]  o_pc;
  logic [4:0]   o_count;

  int tests  = 0;
  int failed = 0;

  always #5 i_clk = ~i_clk;

  fetch_buffer #(.WIDTH(12), .DEPTH(16), .DEPTH_LOG(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .i_pc        (i_pc),
    .i_instr     (i_instr),
    .o_ready     (o_ready),
    .i_dec_ready (i_dec_ready),
    .o_valid     (o_valid),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_count     (o_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs held; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [11:0] pc, input logic [31:0] ins,
                     input logic dr, input logic fl);
    i_valid     = v;
    i_pc        = pc;
    i_instr     = ins;
    i_dec_ready = dr;
    i_flush     = fl;
    @(posedge i_clk);
    #1;
    i_valid     = 1'b0;
    i_dec_ready = 1'b0;
    i_flush     = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_pc = 12'h000;
    i_instr = 32'h0; i_dec_ready = 1'b0;

    // Reset then idle
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_held_count", 128'(o_count), 128'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_valid", 128'(o_valid), 128'h0);
    chk("rst_ready", 128'(o_ready), 128'h1);
    chk("rst_count", 128'(o_count), 128'd0);
    chk("rst_instr", o_instr, {NOP, NOP, NOP, NOP});
    chk("rst_pc",    128'(o_pc), 128'h0);

    // Empty with decode ready: nothing changes
    cyc(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    chk("empty_pop_count", 128'(o_count), 128'd0);
    chk("empty_pop_valid", 128'(o_valid), 128'h0);

    // Fill and bundle
    cyc(1'b1, 12'h000, 32'h00100093, 1'b0, 1'b0);
    chk("lat_first_valid", 128'(o_valid), 128'h1);
    chk("lat_first_instr", 128'(o_instr[31:0]), 128'h00100093);
    cyc(1'b1, 12'h004, 32'h00200113, 1'b0, 1'b0);
    cyc(1'b1, 12'h008, 32'h00300193, 1'b0, 1'b0);
    chk("fill_valid",   128'(o_valid), 128'h7);
    chk("fill_count",   128'(o_count), 128'd3);
    chk("fill_l0_pc",   128'(o_pc[11:0]), 128'h000);
    chk("fill_l1_pc",   128'(o_pc[23:12]), 128'h004);
    chk("fill_l2_ins",  128'(o_instr[95:64]), 128'h00300193);
    chk("fill_l3_nop",  128'(o_instr[127:96]), 128'(NOP));
    chk("fill_l3_pc",   128'(o_pc[47:36]), 128'h000);
    cyc(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    chk("bundle_pop_count", 128'(o_count), 128'd0);
    chk("bundle_pop_valid", 128'(o_valid), 128'h0);

    // Full backpressure
    for (int i = 0; i < 16; i++) cyc(1'b1, 12'(i*4), 32'h10000000 + 32'(i), 1'b0, 1'b0);
    chk("full_ready", 128'(o_ready), 128'h0);
    chk("full_count", 128'(o_count), 128'd16);
    chk("full_valid", 128'(o_valid), 128'hF);
    cyc(1'b1, 12'h040, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("full_drop_count", 128'(o_count), 128'd16);
    chk("full_l0_pc",      128'(o_pc[11:0]), 128'h000);
    cyc(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    chk("full_pop_count", 128'(o_count), 128'd12);
    chk("full_pop_ready", 128'(o_ready), 128'h1);
    chk("full_pop_l0pc",  128'(o_pc[11:0]), 128'h010);
    chk("full_pop_l0ins", 128'(o_instr[31:0]), 128'h10000004);
    repeat (3) cyc(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    chk("drain_count", 128'(o_count), 128'd0);
    chk("drain_last_dropped", 128'(o_pc[11:0]), 128'h000);

    // Simultaneous push and pop
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'h100 + 12'(i*4), 32'h20000000 + 32'(i), 1'b0, 1'b0);
    chk("sim_pre_count", 128'(o_count), 128'd5);
    cyc(1'b1, 12'h200, 32'h30000000, 1'b1, 1'b0);
    chk("sim_count",  128'(o_count), 128'd2);
    chk("sim_valid",  128'(o_valid), 128'h3);
    chk("sim_l0_pc",  128'(o_pc[11:0]), 128'h110);
    chk("sim_l0_ins", 128'(o_instr[31:0]), 128'h20000004);
    chk("sim_l1_pc",  128'(o_pc[23:12]), 128'h200);
    chk("sim_l1_ins", 128'(o_instr[63:32]), 128'h30000000);
    cyc(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    chk("sim_drain", 128'(o_count), 128'd0);

    // Wrap-around: head and tail sit at 9 here; advance both to 14, then straddle the end
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'h300 + 12'(i*4), 32'h33000000 + 32'(i), 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
    chk("wrap_pre_count", 128'(o_count), 128'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'h400 + 12'(i*4), 32'h40000000 + 32'(i), 1'b0, 1'b0);
    chk("wrap_valid", 128'(o_valid), 128'hF);
    chk("wrap_count", 128'(o_count), 128'd4);
    chk("wrap_pc",    128'(o_pc), 128'({12'h40C, 12'h408, 12'h404, 12'h400}));
    chk("wrap_instr", o_instr, {32'h40000003, 32'h40000002, 32'h40000001, 32'h40000000});

    // Flush priority over concurrent push and pop
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'h410 + 12'(i*4), 32'h40000004 + 32'(i), 1'b0, 1'b0);
    chk("flush_pre_count", 128'(o_count), 128'd7);
    cyc(1'b1, 12'h7F0, 32'h77777777, 1'b1, 1'b1);
    chk("flush_count", 128'(o_count), 128'd0);
    chk("flush_valid", 128'(o_valid), 128'h0);
    chk("flush_ready", 128'(o_ready), 128'h1);
    cyc(1'b1, 12'h500, 32'h50000000, 1'b0, 1'b0);
    chk("post_flush_valid",  128'(o_valid), 128'h1);
    chk("post_flush_l0_pc",  128'(o_pc[11:0]), 128'h500);
    chk("post_flush_l0_ins", 128'(o_instr[31:0]), 128'h50000000);
    chk("post_flush_l1_nop", 128'(o_instr[63:32]), 128'(NOP));

    // Asynchronous reset mid-operation drops everything before the next edge
    cyc(1'b1, 12'h504, 32'h50000001, 1'b0, 1'b0);
    chk("pre_async_count", 128'(o_count), 128'd2);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_count", 128'(o_count), 128'd0);
    chk("async_rst_valid", 128'(o_valid), 128'h0);
    chk("async_rst_instr", o_instr, {NOP, NOP, NOP, NOP});
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("after_rst_count", 128'(o_count), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch queue between icache_m and the 4-wide decode stage inside core.
- Accepts one fetched instruction with its PC per cycle from the fetch path.
- Buffers up to DEPTH entries and presents the oldest four to decode as a lane bundle.
- Discards all contents on a pipeline flush (branch mispredict or redirect).

Parameters:
- WIDTH, 12, PC/instruction address width (matches core WIDTH).
- DEPTH, 16, number of entries; power of two, minimum 4.
- DEPTH_LOG, 4, log2(DEPTH); pointer width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous clear of all entries.
- i_valid  input  1  fetch word valid this cycle.
- i_pc  input  WIDTH  address of i_instr.
- i_instr  input  32  instruction word from icache.
- o_ready  output  1  buffer can accept a push this cycle.
- i_dec_ready  input  1  decode accepts the whole presented bundle.
- o_valid  output  4  per-lane valid; lane 0 is the oldest.
- o_instr  output  128  lane k in bits [32k+31:32k].
- o_pc  output  4*WIDTH  lane k in bits [WIDTH*k+WIDTH-1:WIDTH*k].
- o_count  output  DEPTH_LOG+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular array of {pc, instr}, with registered head, tail and count.
- Reset (async, i_rst_n=0):
  - head, tail and count go to 0; o_count=0, o_valid=4'b0000, o_ready=1.
  - Lane outputs show NOP (32'h00000013) with pc 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation drops all entries immediately; no partial bundle survives.
- o_ready = (count < DEPTH), from registered count only. Full cannot accept, even if a pop occurs in the same cycle (no pop-to-push bypass).
- Push: when i_valid && o_ready && !i_flush, write {i_pc, i_instr} at tail on the rising edge, then tail = tail+1 mod DEPTH.
- Lane presentation (combinational from registered state):
  - o_valid[k] = (count > k).
  - Lane k shows the entry at (head+k) mod DEPTH.
  - Invalid lanes show instr 32'h00000013 and pc 0.
- Pop: when i_dec_ready && !i_flush, remove n = popcount(o_valid) entries; head = head+n mod DEPTH. The bundle is consumed all-or-nothing.
- Simultaneous push and pop: both apply; count_next = count + push - n.
- Latency: a word pushed at edge N appears on a lane after edge N (visible in cycle N+1). There is no same-cycle passthrough from i_instr to o_instr.
- Ordering: program order is preserved; lane 0 always holds the oldest resident entry.
- Flush has priority over push and pop.
  - i_flush=1 at edge N: head, tail and count become 0 after the edge.
  - The concurrent push is dropped and the concurrent pop is not counted.
- Wrap-around: pointers are modulo DEPTH. Lanes straddling the array end read entries DEPTH-1, 0, 1, ... correctly.
- Empty with i_dec_ready=1: no state change.
- i_valid while full: the word is ignored. The fetch stage must hold it until o_ready=1.
- o_count equals the registered count, range 0..DEPTH.

Test Plan:
- Reset then idle:
  - Hold i_rst_n=0 for 2 cycles, then release.
  - Expect o_valid=0000, o_ready=1, o_count=0, all lanes 32'h00000013.
- Fill and bundle:
  - Push instrs 0x00100093, 0x00200113, 0x00300193 at pc 0, 4, 8 with i_dec_ready=0.
  - Expect o_valid=0111, o_count=3, lane0 pc 0 / lane2 instr 0x00300193.
  - Then assert i_dec_ready for one cycle: o_count=0.
- Full backpressure:
  - Push 16 words with i_dec_ready=0: o_ready=0, o_count=16.
  - A 17th i_valid with pc 0x40 is dropped.
  - After one pop of 4, o_count=12 and o_ready=1.
  - Lane0 then shows the 5th pushed pc (0x10).
- Simultaneous push and pop:
  - With count=5, push one and pop a 4-lane bundle in the same cycle: expect o_count=2.
  - Lane0 = 5th oldest entry, lane1 = the new word.
- Wrap-around:
  - Cycle 20 pushes and pops so head=14 with 4 resident entries.
  - Lanes show array entries 14, 15, 0, 1 in push order with correct pcs.
- Flush priority:
  - With count=7, assert i_flush together with i_valid and i_dec_ready.
  - Next cycle expect o_count=0, o_valid=0000.
  - A subsequent push appears alone in lane0.
